// File: rtl/cpu_pkg.sv
// +----------------------------------------------------------------------------+
// | cpu_pkg                                                                    |
// | Shared MU0 definitions: sequencer states, opcode constants, IR reset word. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package cpu_pkg;

  typedef enum logic [2:0] {
    ST_HALT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_EXEC1  = 3'd2,
    ST_EXEC2  = 3'd3,
    ST_PAUSED = 3'd4
  } cpu_state_e;

  localparam logic [3:0] c_op_lda = 4'h0;
  localparam logic [3:0] c_op_sta = 4'h1;
  localparam logic [3:0] c_op_add = 4'h2;
  localparam logic [3:0] c_op_sub = 4'h3;
  localparam logic [3:0] c_op_jmp = 4'h4;
  localparam logic [3:0] c_op_jmi = 4'h5;
  localparam logic [3:0] c_op_jeq = 4'h6;
  localparam logic [3:0] c_op_stp = 4'h7;
  localparam logic [3:0] c_op_ldi = 4'h8;
  localparam logic [3:0] c_op_lsl = 4'h9;
  localparam logic [3:0] c_op_lsr = 4'hA;

  localparam logic [15:0] c_ir_reset = 16'h7000;

  // Memory-operand arithmetic needs a second execute cycle for the data read.
  function automatic logic needs_exec2(input logic [3:0] op);
    return (op == c_op_lda) || (op == c_op_add) || (op == c_op_sub);
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    return op > c_op_lsr;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_sequencer.sv
// +----------------------------------------------------------------------------+
// | cpu_sequencer                                                              |
// | MU0 phase sequencer, instruction register, run/halt/step control and       |
// | retired-instruction counter.                                               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter logic AUTO_START = 1'b0,
  parameter int   CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             START,
  input  logic             STEP_MODE,
  input  logic             STEP,
  input  logic [15:0]      MEM_Q,
  output logic             FETCH,
  output logic             EXEC1,
  output logic             EXEC2,
  output logic [3:0]       OP,
  output logic [11:0]      S,
  output logic             HALTED,
  output logic             PAUSED,
  output logic             ILLEGAL,
  output logic [CNT_W-1:0] INSTR_CNT
);

  localparam cpu_state_e c_reset_state = AUTO_START ? ST_FETCH : ST_HALT;

  cpu_state_e       r_state;
  cpu_state_e       w_next_state;
  logic [15:0]      r_ir;
  logic             r_illegal;
  logic [CNT_W-1:0] r_cnt;
  logic             w_retire;
  logic             w_set_illegal;
  logic [3:0]       w_op;

  assign w_op = r_ir[15:12];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= c_reset_state;
      r_ir      <= c_ir_reset;
      r_illegal <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_FETCH) begin
        r_ir <= MEM_Q;
      end
      if (w_set_illegal) begin
        r_illegal <= 1'b1;
      end
      if (w_retire) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_retire      = 1'b0;
    w_set_illegal = 1'b0;
    case (r_state)
      ST_HALT: begin
        if (START) begin
          w_next_state = ST_FETCH;
        end
      end
      ST_FETCH: begin
        w_next_state = ST_EXEC1;
      end
      ST_EXEC1: begin
        if (needs_exec2(w_op)) begin
          w_next_state = ST_EXEC2;
        end else if (w_op == c_op_stp) begin
          w_next_state = ST_HALT;
        end else begin
          w_retire      = 1'b1;
          w_set_illegal = is_illegal(w_op);
        end
      end
      ST_EXEC2: begin
        w_retire = 1'b1;
      end
      ST_PAUSED: begin
        if (STEP || !STEP_MODE) begin
          w_next_state = ST_FETCH;
        end
      end
      default: begin
        w_next_state = c_reset_state;
      end
    endcase
    // Every retiring path shares the same run/pause decision.
    if (w_retire) begin
      w_next_state = STEP_MODE ? ST_PAUSED : ST_FETCH;
    end
  end

  assign FETCH     = (r_state == ST_FETCH);
  assign EXEC1     = (r_state == ST_EXEC1);
  assign EXEC2     = (r_state == ST_EXEC2);
  assign HALTED    = (r_state == ST_HALT);
  assign PAUSED    = (r_state == ST_PAUSED);
  assign OP        = r_ir[15:12];
  assign S         = r_ir[11:0];
  assign ILLEGAL   = r_illegal;
  assign INSTR_CNT = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_cpu_sequencer                                                           |
// | Directed self-checking bench with an instruction-level reference model.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_cpu_sequencer;

  localparam int CNT_W = 4;

  logic             clk;
  logic             reset_n;
  logic             START;
  logic             STEP_MODE;
  logic             STEP;
  logic [15:0]      MEM_Q;
  logic             FETCH;
  logic             EXEC1;
  logic             EXEC2;
  logic [3:0]       OP;
  logic [11:0]      S;
  logic             HALTED;
  logic             PAUSED;
  logic             ILLEGAL;
  logic [CNT_W-1:0] INSTR_CNT;

  int checks   = 0;
  int failures = 0;

  cpu_sequencer #(
    .AUTO_START (1'b0),
    .CNT_W      (CNT_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .START     (START),
    .STEP_MODE (STEP_MODE),
    .STEP      (STEP),
    .MEM_Q     (MEM_Q),
    .FETCH     (FETCH),
    .EXEC1     (EXEC1),
    .EXEC2     (EXEC2),
    .OP        (OP),
    .S         (S),
    .HALTED    (HALTED),
    .PAUSED    (PAUSED),
    .ILLEGAL   (ILLEGAL),
    .INSTR_CNT (INSTR_CNT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: run mode plus position within the current instruction
  // (0 = fetch cycle, 1.. = execute cycles), instruction length from opcode.
  int          m_mode;   // 0 halted, 1 running, 2 paused
  int          m_pos;
  logic [15:0] m_ir;
  int          m_cnt;
  logic        m_ill;
  logic        m_valid = 1'b0;

  always @(posedge clk) begin
    int op;
    int len;
    if (!reset_n) begin
      m_mode  = 0;
      m_pos   = 0;
      m_ir    = 16'h7000;
      m_cnt   = 0;
      m_ill   = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (m_mode == 0) begin
        if (START) begin
          m_mode = 1;
          m_pos  = 0;
        end
      end else if (m_mode == 2) begin
        if (STEP || !STEP_MODE) begin
          m_mode = 1;
          m_pos  = 0;
        end
      end else if (m_pos == 0) begin
        m_ir  = MEM_Q;
        m_pos = 1;
      end else begin
        op  = int'(m_ir[15:12]);
        len = (op == 0 || op == 2 || op == 3) ? 2 : 1;
        if (op == 7) begin
          m_mode = 0;
        end else if (m_pos == len) begin
          m_cnt = (m_cnt + 1) % (1 << CNT_W);
          if (op >= 11) m_ill = 1'b1;
          if (STEP_MODE) m_mode = 2;
          m_pos = 0;
        end else begin
          m_pos = m_pos + 1;
        end
      end
    end
  end

  always @(posedge clk) begin
    logic [4:0] exp_ph;
    #1;
    if (m_valid) begin
      exp_ph = {m_mode == 1 && m_pos == 0, m_mode == 1 && m_pos == 1,
                m_mode == 1 && m_pos == 2, m_mode == 0, m_mode == 2};
      check("model_phase", {27'd0, FETCH, EXEC1, EXEC2, HALTED, PAUSED}, {27'd0, exp_ph});
      check("model_ir", {16'd0, OP, S}, {16'd0, m_ir});
      check("model_illegal", {31'd0, ILLEGAL}, {31'd0, m_ill});
      check("model_cnt", {28'd0, INSTR_CNT}, m_cnt);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_fetch(input string name);
    int i;
    for (i = 0; i < 10 && FETCH !== 1'b1; i++) @(negedge clk);
    check(name, {31'd0, FETCH}, 32'd1);
  endtask

  initial begin
    reset_n   = 1'b0;
    START     = 1'b0;
    STEP_MODE = 1'b0;
    STEP      = 1'b0;
    MEM_Q     = 16'h8005;
    tick(3);
    check("reset_halted", {31'd0, HALTED}, 32'd1);
    check("reset_ir", {16'd0, OP, S}, 32'h7000);
    check("reset_cnt", {28'd0, INSTR_CNT}, 32'd0);
    check("reset_fetch", {31'd0, FETCH}, 32'd0);

    // LDI: two-cycle instruction
    reset_n = 1'b1;
    START   = 1'b1;
    tick(1);
    check("start_fetch", {31'd0, FETCH}, 32'd1);
    START = 1'b0;
    tick(1);
    check("ldi_exec1", {31'd0, EXEC1}, 32'd1);
    check("ldi_op_s", {16'd0, OP, S}, 32'h8005);
    tick(1);
    check("ldi_next_fetch", {31'd0, FETCH}, 32'd1);
    check("ldi_cnt", {28'd0, INSTR_CNT}, 32'd1);

    // ADD: three-cycle instruction
    MEM_Q = 16'h2010;
    tick(2);
    check("add_exec2", {31'd0, EXEC2}, 32'd1);
    check("add_op_held", {28'd0, OP}, 32'd2);
    tick(1);
    check("add_next_fetch", {31'd0, FETCH}, 32'd1);
    check("add_cnt", {28'd0, INSTR_CNT}, 32'd2);

    // STP halts without retiring; STEP has no effect in HALT
    MEM_Q = 16'h7000;
    tick(2);
    check("stp_halted", {31'd0, HALTED}, 32'd1);
    check("stp_cnt", {28'd0, INSTR_CNT}, 32'd2);
    STEP = 1'b1;
    tick(3);
    check("step_ignored", {31'd0, HALTED}, 32'd1);
    STEP = 1'b0;

    // Illegal opcode retires as NOP and sets the sticky flag
    MEM_Q = 16'hB123;
    START = 1'b1;
    tick(1);
    wait_fetch("restart_fetch");
    START = 1'b0;
    tick(1);
    check("ill_exec1_flag", {31'd0, ILLEGAL}, 32'd0);
    tick(1);
    check("ill_flag", {31'd0, ILLEGAL}, 32'd1);
    check("ill_fetch", {31'd0, FETCH}, 32'd1);
    check("ill_cnt", {28'd0, INSTR_CNT}, 32'd3);

    // Single-step: LDA then pause
    STEP_MODE = 1'b1;
    MEM_Q     = 16'h0042;
    tick(3);
    check("step_paused", {31'd0, PAUSED}, 32'd1);
    check("step_cnt", {28'd0, INSTR_CNT}, 32'd4);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("pause_hold", {29'd0, PAUSED, FETCH, EXEC1}, 32'd4);
      check("pause_ir", {16'd0, OP, S}, 32'h0042);
    end
    STEP = 1'b1;
    tick(1);
    check("step_release", {31'd0, FETCH}, 32'd1);
    STEP      = 1'b0;
    STEP_MODE = 1'b0;
    tick(3);
    check("run_after_step", {31'd0, FETCH}, 32'd1);
    check("ill_sticky", {31'd0, ILLEGAL}, 32'd1);
    check("run_cnt", {28'd0, INSTR_CNT}, 32'd5);

    // Reset in the middle of an ADD aborts it
    MEM_Q = 16'h2001;
    tick(2);
    check("pre_reset_exec2", {31'd0, EXEC2}, 32'd1);
    reset_n = 1'b0;
    tick(1);
    check("midreset_halted", {31'd0, HALTED}, 32'd1);
    check("midreset_ir", {16'd0, OP, S}, 32'h7000);
    check("midreset_cnt", {28'd0, INSTR_CNT}, 32'd0);
    check("midreset_ill", {31'd0, ILLEGAL}, 32'd0);
    reset_n = 1'b1;

    // Counter wrap after 16 retires
    MEM_Q = 16'h8001;
    START = 1'b1;
    tick(1);
    wait_fetch("wrap_start");
    START = 1'b0;
    tick(30);
    check("wrap_cnt15", {28'd0, INSTR_CNT}, 32'd15);
    tick(2);
    check("wrap_cnt0", {28'd0, INSTR_CNT}, 32'd0);
    check("wrap_fetch", {31'd0, FETCH}, 32'd1);

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
